present_round_core: RTL and testbench



---
 rtl/present_pkg.sv | 41 ++++
 rtl/present_key_schedule.sv | 54 +++++
 rtl/present_sbox4.sv | 11 +
 rtl/present_sbox_parallel_64bit.sv | 14 +
 rtl/present_round_core.sv | 127 ++++++++++++
 tb/tb_present_round_core.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared PRESENT constants, S-box/P-layer helpers and FSM state type
package present_pkg;

  localparam int ROUNDS_DEFAULT = 31;

  // S-box table, entry x in nibble x (entry 0 in bits [3:0])
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  // Destination bit of source bit i in the permutation layer
  function automatic logic [5:0] p_index(input logic [5:0] i);
    if (i == 6'd63) begin
      return 6'd63;
    end
    return 6'((16 * int'(i)) % 63);
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      y[p_index(6'(i))] = x[i];
    end
    return y;
  endfunction

  // Round key is the top 64 bits of the key; caller passes the key MSB-aligned in 128 bits
  function automatic logic [63:0] round_key(input logic [127:0] key_top);
    return key_top[127:64];
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// rtl/present_key_schedule.sv - combinational PRESENT key update for 80/128-bit keys
module present_key_schedule #(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] i_key,
  input  logic [4:0]       i_rc,
  output logic [KEY_W-1:0] o_key
);

  logic [KEY_W-1:0] w_rot;

  // Rotate left by 61
  assign w_rot = {i_key[KEY_W-62:0], i_key[KEY_W-1:KEY_W-61]};

  if (KEY_W == 80) begin : g_k80
    logic [3:0] w_sb_hi;

    present_sbox4 u_sbox_hi (
      .i_nib (w_rot[79:76]),
      .o_nib (w_sb_hi)
    );

    // Substitute top nibble and mix in the round counter
    always_comb begin
      o_key        = w_rot;
      o_key[79:76] = w_sb_hi;
      o_key[19:15] = w_rot[19:15] ^ i_rc;
    end
  end else if (KEY_W == 128) begin : g_k128
    logic [3:0] w_sb_hi;
    logic [3:0] w_sb_lo;

    present_sbox4 u_sbox_hi (
      .i_nib (w_rot[127:124]),
      .o_nib (w_sb_hi)
    );

    present_sbox4 u_sbox_lo (
      .i_nib (w_rot[123:120]),
      .o_nib (w_sb_lo)
    );

    // Substitute top two nibbles and mix in the round counter
    always_comb begin
      o_key          = w_rot;
      o_key[127:124] = w_sb_hi;
      o_key[123:120] = w_sb_lo;
      o_key[66:62]   = w_rot[66:62] ^ i_rc;
    end
  end else begin : g_bad_key_w
    $error("present_key_schedule: KEY_W must be 80 or 128");
  end

endmodule

// File: rtl/present_sbox4.sv
// rtl/present_sbox4.sv - single 4-bit PRESENT S-box
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = sbox_lookup(i_nib);

endmodule

// File: rtl/present_sbox_parallel_64bit.sv
// rtl/present_sbox_parallel_64bit.sv - 16 parallel S-boxes over a 64-bit state
module present_sbox_parallel_64bit (
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);

  for (genvar g = 0; g < 16; g++) begin : g_nib
    present_sbox4 u_sbox (
      .i_nib (i_data[4*g +: 4]),
      .o_nib (o_data[4*g +: 4])
    );
  end

endmodule

// File: rtl/present_round_core.sv
// rtl/present_round_core.sv - iterative PRESENT encryptor, one round per clock; PRESENT_ABORT_EN adds abort input
module present_round_core
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PRESENT_ABORT_EN
  input  logic             abort,
`endif
  output logic [63:0]      out_data
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_round_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_round_core: ROUNDS must be 1..31");
  end

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  fsm_t             r_fsm;
  logic [4:0]       r_rc;
  logic [63:0]      r_state;
  logic [KEY_W-1:0] r_key;

  fsm_t             w_fsm_nxt;
  logic [4:0]       w_rc_nxt;
  logic [63:0]      w_state_nxt;
  logic [KEY_W-1:0] w_key_nxt;

  logic [127:0]     w_key_top;
  logic [63:0]      w_rk;
  logic [63:0]      w_sbox_out;
  logic [63:0]      w_round_out;
  logic [KEY_W-1:0] w_key_upd;

  assign w_key_top = 128'(r_key) << (128 - KEY_W);
  assign w_rk      = round_key(w_key_top);

  present_sbox_parallel_64bit u_sbox_layer (
    .i_data (r_state ^ w_rk),
    .o_data (w_sbox_out)
  );

  assign w_round_out = p_layer(w_sbox_out);

  present_key_schedule #(
    .KEY_W (KEY_W)
  ) u_key_schedule (
    .i_key (r_key),
    .i_rc  (r_rc),
    .o_key (w_key_upd)
  );

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_rc    <= '0;
      r_state <= '0;
      r_key   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_rc    <= w_rc_nxt;
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
    end
  end

  // Next-state: accept in IDLE, one round per cycle in RUN, hold result in DONE
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_rc_nxt    = r_rc;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    case (r_fsm)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = in_data;
          w_key_nxt   = in_key;
          w_rc_nxt    = 5'd1;
          w_fsm_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = w_round_out;
        w_key_nxt   = w_key_upd;
        if (r_rc == RC_LAST) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_rc_nxt = r_rc + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
`ifdef PRESENT_ABORT_EN
    // Abort wins over any handshake; the job in flight is dropped
    if (abort && (r_fsm != ST_IDLE)) begin
      w_fsm_nxt = ST_IDLE;
      w_rc_nxt  = '0;
    end
`endif
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  // Final whitening with the last key; output is forced to zero outside DONE
  assign out_data  = out_valid ? (r_state ^ w_rk) : 64'd0;

endmodule

// File: tb/tb_present_round_core.sv
// tb/tb_present_round_core.sv - directed self-checking bench for present_round_core
module tb_present_round_core;

  logic         clk;
  logic         rst_n;

  logic         in_valid80;
  logic         in_ready80;
  logic [63:0]  in_data80;
  logic [79:0]  in_key80;
  logic         out_valid80;
  logic         out_ready80;
  logic [63:0]  out_data80;

  logic         in_valid128;
  logic         in_ready128;
  logic [63:0]  in_data128;
  logic [127:0] in_key128;
  logic         out_valid128;
  logic         out_ready128;
  logic [63:0]  out_data128;

`ifdef PRESENT_ABORT_EN
  logic         abort80;
  logic         abort128;
`endif

  int n_pass;
  int n_total;

  present_round_core #(
    .KEY_W (80)
  ) dut80 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid80),
    .in_ready  (in_ready80),
    .in_data   (in_data80),
    .in_key    (in_key80),
    .out_valid (out_valid80),
    .out_ready (out_ready80),
`ifdef PRESENT_ABORT_EN
    .abort     (abort80),
`endif
    .out_data  (out_data80)
  );

  present_round_core #(
    .KEY_W (128)
  ) dut128 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid128),
    .in_ready  (in_ready128),
    .in_data   (in_data128),
    .in_key    (in_key128),
    .out_valid (out_valid128),
    .out_ready (out_ready128),
`ifdef PRESENT_ABORT_EN
    .abort     (abort128),
`endif
    .out_data  (out_data128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start80(input logic [79:0] k, input logic [63:0] pt);
    in_key80   = k;
    in_data80  = pt;
    in_valid80 = 1'b1;
    @(posedge clk); #1;
    in_valid80 = 1'b0;
  endtask

  task automatic wait_out80(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid80) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake80(input string tag);
    out_ready80 = 1'b1;
    @(posedge clk); #1;
    out_ready80 = 1'b0;
    chk({tag, "_ovalid_drop"}, 128'(out_valid80), 128'(1'b0));
    chk({tag, "_odata_zero"}, 128'(out_data80), 128'd0);
    chk({tag, "_iready_back"}, 128'(in_ready80), 128'(1'b1));
  endtask

  task automatic job80(input string tag, input logic [79:0] k, input logic [63:0] pt,
                       input logic [63:0] exp_ct);
    int lat;
    chk({tag, "_iready_idle"}, 128'(in_ready80), 128'(1'b1));
    start80(k, pt);
    chk({tag, "_iready_busy"}, 128'(in_ready80), 128'(1'b0));
    chk({tag, "_odata_run"}, 128'(out_data80), 128'd0);
    wait_out80(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(31));
    chk({tag, "_ct"}, 128'(out_data80), 128'(exp_ct));
    handshake80(tag);
  endtask

  initial begin
    int lat;
    int seen;
    n_pass  = 0;
    n_total = 0;

    rst_n        = 1'b0;
    in_valid80   = 1'b0;
    in_data80    = '0;
    in_key80     = '0;
    out_ready80  = 1'b0;
    in_valid128  = 1'b0;
    in_data128   = '0;
    in_key128    = '0;
    out_ready128 = 1'b0;
`ifdef PRESENT_ABORT_EN
    abort80      = 1'b0;
    abort128     = 1'b0;
`endif

    // Reset state, with in_valid asserted to show it is ignored
    in_valid80 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iready", 128'(in_ready80), 128'(1'b1));
    chk("rst_ovalid", 128'(out_valid80), 128'(1'b0));
    chk("rst_odata", 128'(out_data80), 128'd0);
    chk("rst_ovalid128", 128'(out_valid128), 128'(1'b0));
    in_valid80 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Standard 80-bit vectors
    job80("k0_p0", 80'd0, 64'd0, 64'h5579C1387B228445);
    job80("kf_pf", {80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2);

    // Backpressure in DONE with the next job already offered
    start80(80'd0, {64{1'b1}});
    wait_out80(lat);
    chk("bp_latency", 128'(lat), 128'(31));
    chk("bp_ct", 128'(out_data80), 128'h0000000000000000A112FFC72F68417B);
    in_key80   = {80{1'b1}};
    in_data80  = 64'd0;
    in_valid80 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 128'(out_data80), 128'h0000000000000000A112FFC72F68417B);
      chk("bp_hold_iready", 128'(in_ready80), 128'(1'b0));
      chk("bp_hold_ovalid", 128'(out_valid80), 128'(1'b1));
    end
    out_ready80 = 1'b1;
    @(posedge clk); #1;
    out_ready80 = 1'b0;
    chk("bp_post_hs_ovalid", 128'(out_valid80), 128'(1'b0));
    chk("bp_post_hs_iready", 128'(in_ready80), 128'(1'b1));
    @(posedge clk); #1;
    chk("bp_accept_next", 128'(in_ready80), 128'(1'b0));
    in_valid80 = 1'b0;
    wait_out80(lat);
    chk("bp_next_latency", 128'(lat), 128'(31));
    chk("bp_next_ct", 128'(out_data80), 128'hE72C46C0F5945049);
    handshake80("bp_next");

    // 128-bit key vector
    chk("k128_iready_idle", 128'(in_ready128), 128'(1'b1));
    in_key128   = '0;
    in_data128  = '0;
    in_valid128 = 1'b1;
    @(posedge clk); #1;
    in_valid128 = 1'b0;
    chk("k128_iready_busy", 128'(in_ready128), 128'(1'b0));
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid128) begin
        lat = n;
        break;
      end
    end
    chk("k128_latency", 128'(lat), 128'(31));
    chk("k128_ct", 128'(out_data128), 128'h96DB702A2E6900AF);
    out_ready128 = 1'b1;
    @(posedge clk); #1;
    out_ready128 = 1'b0;
    chk("k128_ovalid_drop", 128'(out_valid128), 128'(1'b0));
    chk("k128_iready_back", 128'(in_ready128), 128'(1'b1));

    // Reset in the middle of round 12
    start80(80'd0, 64'd0);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ovalid", 128'(out_valid80), 128'(1'b0));
    chk("midrst_iready", 128'(in_ready80), 128'(1'b1));
    chk("midrst_odata", 128'(out_data80), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    job80("after_rst", {80{1'b1}}, 64'd0, 64'hE72C46C0F5945049);

`ifdef PRESENT_ABORT_EN
    // Abort at round 5: back to IDLE, no output pulse, next job unaffected
    start80(80'd0, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    abort80 = 1'b1;
    @(posedge clk); #1;
    abort80 = 1'b0;
    chk("abort_iready", 128'(in_ready80), 128'(1'b1));
    chk("abort_ovalid", 128'(out_valid80), 128'(1'b0));
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid80) seen++;
    end
    chk("abort_no_pulse", 128'(seen), 128'd0);
    job80("after_abort", {80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2);
`else
    seen = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
